// File: rtl/spi_slave_if_if.sv
// SPI slave front end bundle: serial pins plus RAM-facing word/byte path.
// master = SPI master and RAM side, slave = the front end itself.
interface spi_slave_if_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: MOSI frames to RAM words,
// RAM read bytes back out on MISO, MSB first.
module spi_slave_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_if_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam int CW = $clog2(FRAME_W + 1);
    localparam int TW = $clog2(DATA_W);

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      bit_cnt;
    logic [FRAME_W-2:0] shreg;
    logic [DATA_W-1:0]  tx_sh;
    logic [TW-1:0]      tx_left;
    logic               tx_busy;
    logic               tx_done;
    logic               rd_addr_seen;
    logic               miso_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               shifting;
    logic               last_bit;
    logic               tx_wait;

    assign shifting = (state == WRITE || state == READ_ADD ||
                       state == READ_DATA) &&
                      (bit_cnt != CW'(FRAME_W));
    assign last_bit = shifting && (bit_cnt == CW'(FRAME_W - 1));
    assign tx_wait  = (state == READ_DATA) &&
                      (bit_cnt == CW'(FRAME_W)) &&
                      !tx_busy && !tx_done;

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: select bit picks the frame type, SS_n high ends it.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!bus.SS_n) state_n = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)         state_n = IDLE;
                else if (!bus.MOSI)   state_n = WRITE;
                else if (rd_addr_seen) state_n = READ_DATA;
                else                  state_n = READ_ADD;
            end
            default: begin
                if (bus.SS_n) state_n = IDLE;
            end
        endcase
    end

    // Datapath: word deserialiser, read-address flag, MISO serialiser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            tx_sh        <= '0;
            tx_left      <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
            miso_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state != IDLE && bus.SS_n) begin
                bit_cnt <= '0;
                tx_left <= '0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                miso_q  <= 1'b0;
            end else begin
                if (shifting) begin
                    shreg   <= {shreg[FRAME_W-3:0], bus.MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        rx_data_q  <= {shreg, bus.MOSI};
                        rx_valid_q <= 1'b1;
                        if (state == READ_ADD) rd_addr_seen <= 1'b1;
                    end
                end
                if (tx_wait && bus.tx_valid) begin
                    tx_sh   <= {bus.tx_data[DATA_W-2:0], 1'b0};
                    miso_q  <= bus.tx_data[DATA_W-1];
                    tx_left <= TW'(DATA_W - 1);
                    tx_busy <= 1'b1;
                end else if (tx_busy) begin
                    if (tx_left != '0) begin
                        miso_q  <= tx_sh[DATA_W-1];
                        tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                        tx_left <= tx_left - 1'b1;
                    end else begin
                        miso_q       <= 1'b0;
                        tx_busy      <= 1'b0;
                        tx_done      <= 1'b1;
                        rd_addr_seen <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI-slave-with-RAM subsystem; sits directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit words {cmd[1:0], payload[7:0]} and presents them to the RAM with a one-cycle rx_valid strobe.
- For read-data frames, captures the RAM's returned byte (tx_valid/tx_data) and serialises it MSB-first on MISO.
- clk is the SPI serial clock. All logic runs on its rising edge.

Parameters:
- FRAME_W, 10, width of the parallel word sent to the RAM.
- DATA_W, 8, width of the read-back byte shifted out on MISO.

Ports:
- clk  input  1  SPI serial clock; all sampling on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- SS_n  input  1  slave select, active low; frame boundary.
- MOSI  input  1  serial data from master; sampled on rising edge.
- MISO  output  1  serial read data to master; registered.
- rx_data  output  FRAME_W  parallel word to RAM (din).
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  DATA_W  read byte from RAM (dout).
- tx_valid  input  1  RAM read-data valid.

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE; rx_data=0; rx_valid=0; MISO=0; bit counter=0; rd_addr_seen=0.
- Reset overrides everything, including mid-frame. A partial frame is discarded.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Edge numbering: E0 is the first edge at which IDLE samples SS_n=0.
- IDLE -> CHK_CMD at E0. MOSI is ignored at E0.
- CHK_CMD, at E1, samples MOSI as the select bit:
  - select 0 -> WRITE.
  - select 1 and rd_addr_seen=0 -> READ_ADD.
  - select 1 and rd_addr_seen=1 -> READ_DATA.
- Shift phase (WRITE, READ_ADD, READ_DATA):
  - E2..E11 shift 10 MOSI bits MSB-first into the shift register.
  - At E11, rx_data is loaded with the full word and rx_valid is set. rx_valid is high for exactly one cycle (E11 to E12).
  - Bits after the 10th are ignored. No second rx_valid is issued in the same frame.
- READ_ADD: sets rd_addr_seen=1 at E11.
- READ_DATA:
  - After rx_valid, waits for tx_valid=1 at a rising edge. With a 1-cycle RAM this is E13.
  - At that edge: latch tx_data and drive MISO=tx_data[7] immediately (registered).
  - Each following edge shifts out the next bit, down to bit 0: 8 bits total, each held for one cycle.
  - After bit 0, MISO returns to 0 and rd_addr_seen clears.
  - tx_valid pulses outside READ_DATA's wait phase are ignored.
- Frame end:
  - After the shift/serialise phase completes, the FSM holds its completion state until SS_n=1, then goes to IDLE.
  - SS_n=1 sampled in any non-IDLE state -> IDLE at that edge. Counters clear and MISO=0.
  - No rx_valid is issued for an incomplete frame. rd_addr_seen is retained unless a READ_DATA serialisation finished.
- MISO is 0 whenever not serialising.
- rx_data holds its last value between frames.
- No payload/cmd checking: rx_data[9:8] is passed through as shifted in.

Test Plan:
- Write address: SS_n low; select=0; bits 00_0000_0101; SS_n high -> rx_valid single pulse at E11; rx_data=10'h005; MISO stays 0.
- Write data: select=0; bits 01_1010_0101 -> rx_data=10'h1A5 with one rx_valid pulse; rd_addr_seen unchanged (0).
- Read address then read data, with a RAM model returning 8'hC3 one cycle after rx_valid:
  - Read address: select=1; bits 10_0000_0101 -> rx_data=10'h205; rd_addr_seen=1.
  - Read data: next frame select=1; bits 11_xxxx_xxxx -> rx_valid at E11; tx_valid at E13; MISO=1,1,0,0,0,0,1,1 on E13..E20; then MISO=0 and rd_addr_seen=0.
- Read without prior address: select=1 with rd_addr_seen=0 -> FSM enters READ_ADD (not READ_DATA); rx_data=shifted word; no MISO activity.
- Abort: SS_n rises after 5 data bits of a WRITE frame -> no rx_valid; FSM in IDLE next edge; the following full frame decodes correctly.
- Reset mid-READ_DATA serialisation (after 3 bits out), rst_n=0 for one edge -> MISO=0, state IDLE, rd_addr_seen=0, rx_valid=0.
